mdlu_iterative: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers. Sits beside the ALU in the MIPS core.

---
 rtl/mdlu_iterative_if.sv | 29 ++
 rtl/mdlu_iterative.sv | 180 ++++++++++++++++++
 tb/tb_mdlu_iterative.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdlu_iterative_if.sv
// Request/result bundle between the MIPS core and the iterative mul/div unit.
// Handshake: a request is taken on the rising edge where start=1 and the unit
// is idle (busy=0). start is never queued. done pulses for one cycle when hi/lo
// take their new values. div_by_zero is valid with done and holds until the
// next done.
interface mdlu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, is_signed, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, is_signed, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdlu_iterative.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Ops: 0=MULT (shift-add radix-2), 1=DIV (restoring radix-2), 2=ZERO, 3=no-op.
// The unit works on operand magnitudes and applies the result signs in FIN.
module mdlu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mdlu_iterative_if.slave bus,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_ZERO = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // acc: partial product high half (MULT) or partial remainder (DIV)
  logic [WIDTH:0]     acc_q, acc_d;
  // mq: multiplier being consumed (MULT) or dividend/quotient (DIV)
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;   // negate product / quotient
  logic               neg_hi_q, neg_hi_d;   // negate remainder
  logic               dz_q, dz_d;           // current DIV has b==0
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Next-state, datapath iteration and result formatting
  always_comb begin
    a_neg     = bus.is_signed & bus.a[WIDTH-1];
    b_neg     = bus.is_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    mul_sum   = mq_q[0] ? (acc_q + {1'b0, bmag_q}) : acc_q;
    div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, bmag_q};
    prod_mag  = {acc_q[WIDTH-1:0], mq_q};
    prod_res  = neg_lo_q ? -prod_mag : prod_mag;
    quo_res   = neg_lo_q ? -mq_q : mq_q;
    rem_res   = neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    bmag_d   = bmag_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.op == OP_MULT || bus.op == OP_DIV)) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mq_d     = a_mag;
          bmag_d   = b_mag;
          araw_d   = bus.a;
          is_div_d = (bus.op == OP_DIV);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = (bus.op == OP_DIV) && (bus.b == '0);
        end else if (bus.start && bus.op == OP_ZERO) begin
          hi_d   = '0;
          lo_d   = '0;
          done_d = 1'b1;
          dbz_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff;
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIN;
      end
      S_FIN: begin
        if (!is_div_q) begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
        dbz_d   = is_div_q & dz_q;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      bmag_q   <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      bmag_q   <= bmag_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mdlu_iterative.sv
// Directed bench for mdlu_iterative at WIDTH=32.
module tb_mdlu_iterative;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  mdlu_iterative_if #(.WIDTH(32)) bus ();

  mdlu_iterative #(.WIDTH(32)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for done. lat = number of edges after the
  // start edge at which done is first seen (-1 on timeout); bcnt = cycles
  // with busy=1 over the same window.
  task automatic run_op(input logic [1:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.is_signed = sgn; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D;
    lat = -1; bcnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b dbz=%b expected 0/0/0",
               bus.busy, bus.done, bus.div_by_zero);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs hi=%h lo=%h state=%0d expected 0/0/0", bus.hi, bus.lo, dbg_state);
    end
  endtask

  task automatic test_mult();
    int lat, bcnt;
    run_op(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d expected 33", lat); end
    checks++;
    if (bcnt !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d expected 33", bcnt); end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      errors++; $display("FAIL mult_umax hi=%h lo=%h expected fffffffe/00000001", bus.hi, bus.lo);
    end
    run_op(2'd0, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    checks++;
    if (lat !== 33 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_signed lat=%0d hi=%h lo=%h expected 33/ffffffff/ffffffeb", lat, bus.hi, bus.lo);
    end
    run_op(2'd0, 1'b0, 32'h8000_0000, 32'd2, lat, bcnt);
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL mult_carry hi=%h lo=%h expected 00000001/00000000", bus.hi, bus.lo);
    end
    run_op(2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    checks++;
    if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL mult_min_sq hi=%h lo=%h expected 40000000/00000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int lat, bcnt;
    run_op(2'd1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    checks++;
    if (lat !== 33 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_signed lat=%0d lo=%h hi=%h expected 33/fffffffd/ffffffff", lat, bus.lo, bus.hi);
    end
    run_op(2'd1, 1'b0, 32'd100, 32'd7, lat, bcnt);
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_unsigned lo=%h hi=%h dbz=%b expected 0000000e/00000002/0", bus.lo, bus.hi, bus.div_by_zero);
    end
    run_op(2'd1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
      errors++; $display("FAIL div_neg_divisor lo=%h hi=%h expected fffffffd/00000001", bus.lo, bus.hi);
    end
    run_op(2'd1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_min_m1 lo=%h hi=%h dbz=%b expected 80000000/00000000/0", bus.lo, bus.hi, bus.div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run_op(2'd1, 1'b0, 32'h1234_5678, 32'h0, lat, bcnt);
    checks++;
    if (lat !== 33 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234_5678 || bus.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL div0_unsigned lat=%0d lo=%h hi=%h dbz=%b expected 33/ffffffff/12345678/1",
                         lat, bus.lo, bus.hi, bus.div_by_zero);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.div_by_zero !== 1'b1 || bus.hi !== 32'h1234_5678) begin
      errors++; $display("FAIL div0_hold dbz=%b hi=%h expected 1/12345678", bus.div_by_zero, bus.hi);
    end
    run_op(2'd1, 1'b0, 32'd9, 32'd3, lat, bcnt);
    checks++;
    if (bus.lo !== 32'd3 || bus.hi !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div0_clear lo=%h hi=%h dbz=%b expected 00000003/00000000/0", bus.lo, bus.hi, bus.div_by_zero);
    end
    run_op(2'd1, 1'b1, 32'hFFFF_FFF9, 32'h0, lat, bcnt);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9 || bus.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL div0_signed lo=%h hi=%h dbz=%b expected ffffffff/fffffff9/1", bus.lo, bus.hi, bus.div_by_zero);
    end
  endtask

  task automatic test_zero();
    int lat, bcnt;
    run_op(2'd0, 1'b0, 32'd6, 32'd7, lat, bcnt);
    checks++;
    if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL zero_premult lo=%h hi=%h expected 0000002a/00000000", bus.lo, bus.hi);
    end
    run_op(2'd1, 1'b0, 32'd5, 32'd0, lat, bcnt);
    run_op(2'd2, 1'b0, 32'd1, 32'd1, lat, bcnt);
    checks++;
    if (lat !== 0 || bcnt !== 0) begin
      errors++; $display("FAIL zero_timing lat=%0d busy_cycles=%0d expected 0/0", lat, bcnt);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL zero_result hi=%h lo=%h dbz=%b expected 0/0/0", bus.hi, bus.lo, bus.div_by_zero);
    end
  endtask

  task automatic test_reserved();
    int lat, bcnt;
    int activity;
    run_op(2'd0, 1'b0, 32'd3, 32'd5, lat, bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    activity = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.busy || bus.done) activity++;
      @(negedge clk);
    end
    checks++;
    if (activity !== 0 || bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL reserved_op activity=%0d lo=%h hi=%h expected 0/0000000f/00000000", activity, bus.lo, bus.hi);
    end
  endtask

  task automatic test_ignored_start();
    int lat, dones;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.is_signed = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 5) begin bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd5; end
      if (n == 6) bus.start = 1'b0;
      if (bus.done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 33 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++; $display("FAIL ignored_start lat=%0d lo=%h hi=%h expected 33/0000000e/00000002", lat, bus.lo, bus.hi);
    end
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL ignored_not_queued activity=%0d expected 0", dones); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt, dones;
    run_op(2'd0, 1'b0, 32'd3, 32'd5, lat, bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.is_signed = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL reset_mid_op busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_no_done dones=%0d expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(2'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, lat, bcnt);
    checks++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL b2b_first hi=%h lo=%h expected 00000001/fffffffe", bus.hi, bus.lo);
    end
    // still inside the done cycle: present the next request now
    bus.start = 1'b1; bus.op = 2'd1; bus.is_signed = 1'b0; bus.a = 32'd9; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b expected 1", bus.busy); end
    lat = -1;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 33 || bus.lo !== 32'd3 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL b2b_second lat=%0d lo=%h hi=%h expected 33/00000003/00000000", lat, bus.lo, bus.hi);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_zero();
    test_reserved();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
